// File: rtl/key_cmd_pkg.sv
// Shared constants and types for the PS/2 key-to-command decoder.
// WASD scancodes exist only when KEY_CMD_WASD_EN is defined.
package key_cmd_pkg;

  localparam logic [3:0] CMD_LEFT  = 4'b0000;
  localparam logic [3:0] CMD_RIGHT = 4'b0001;
  localparam logic [3:0] CMD_UP    = 4'b0010;
  localparam logic [3:0] CMD_DOWN  = 4'b0011;
  localparam logic [3:0] CMD_RESET = 4'b1000;
  localparam logic [3:0] CMD_NONE  = 4'b1111;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_R     = 8'h2D;
`ifdef KEY_CMD_WASD_EN
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
`endif

  // One held bit per command; WASD keys reuse the arrow bits.
  localparam logic [4:0] HELD_LEFT  = 5'b00001;
  localparam logic [4:0] HELD_RIGHT = 5'b00010;
  localparam logic [4:0] HELD_UP    = 5'b00100;
  localparam logic [4:0] HELD_DOWN  = 5'b01000;
  localparam logic [4:0] HELD_RESET = 5'b10000;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
    logic [4:0] mask;
  } key_hit_t;

  localparam key_hit_t KEY_MISS = {1'b0, CMD_NONE, 5'b00000};

  function automatic key_hit_t key_hit(input logic [3:0] code, input logic [4:0] mask);
    key_hit_t r;
    r.hit  = 1'b1;
    r.code = code;
    r.mask = mask;
    return r;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge. Storage is not reset.
module cmd_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_en;
  logic              pop_en;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = mem[rd_ptr];
  assign fill    = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_cmd_decoder.sv
// PS/2 scancode stream to 2048 game commands: prefix FSM, held-key tracking and
// a command FIFO. Define KEY_CMD_WASD_EN to also map W/A/S/D to the arrows.
module key_cmd_decoder
  import key_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH         = 4,
  parameter int TRIGGER_ON_RELEASE = 1,
  parameter int TIMEOUT_CYCLES     = 2000000
) (
  input  logic                         CLK100MHZ,
  input  logic                         CPU_RESET,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic [3:0]                   cmd,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fill,
  output logic                         overflow
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  kbd_state_t      state;
  kbd_state_t      state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [4:0]      held;
  logic [4:0]      held_nxt;
  logic            is_make;
  logic            is_brk;
  logic            is_ext;
  key_hit_t        key_p0;
  logic            vld_p0;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [3:0]      fifo_head;

  function automatic key_hit_t decode_key(input logic ext, input logic [7:0] sc);
    key_hit_t r;
    r = KEY_MISS;
    if (ext) begin
      case (sc)
        SC_LEFT:  r = key_hit(CMD_LEFT,  HELD_LEFT);
        SC_RIGHT: r = key_hit(CMD_RIGHT, HELD_RIGHT);
        SC_UP:    r = key_hit(CMD_UP,    HELD_UP);
        SC_DOWN:  r = key_hit(CMD_DOWN,  HELD_DOWN);
        default:  r = KEY_MISS;
      endcase
    end else begin
      case (sc)
        SC_R:     r = key_hit(CMD_RESET, HELD_RESET);
`ifdef KEY_CMD_WASD_EN
        SC_W:     r = key_hit(CMD_UP,    HELD_UP);
        SC_A:     r = key_hit(CMD_LEFT,  HELD_LEFT);
        SC_S:     r = key_hit(CMD_DOWN,  HELD_DOWN);
        SC_D:     r = key_hit(CMD_RIGHT, HELD_RIGHT);
`endif
        default:  r = KEY_MISS;
      endcase
    end
    return r;
  endfunction

  // Stage p0: classify the byte against the prefix state and decide the push
  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    is_ext    = 1'b0;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == SC_EXT)      state_nxt = EXT;
          else if (byte_data == SC_BRK) state_nxt = BRK;
          else                          is_make   = 1'b1;
        end
        EXT: begin
          if (byte_data == SC_BRK) begin
            state_nxt = EXT_BRK;
          end else begin
            is_make   = 1'b1;
            is_ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          is_brk    = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          is_brk    = 1'b1;
          is_ext    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      state_nxt = IDLE;
    end

    key_p0   = decode_key(is_ext, byte_data);
    held_nxt = held;
    vld_p0   = 1'b0;
    if (key_p0.hit && is_make) begin
      held_nxt = held | key_p0.mask;
      if (TRIGGER_ON_RELEASE == 0) vld_p0 = ((held & key_p0.mask) == 5'b00000);
    end
    if (key_p0.hit && is_brk) begin
      held_nxt = held & ~key_p0.mask;
      if (TRIGGER_ON_RELEASE != 0) vld_p0 = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      state    <= IDLE;
      to_cnt   <= '0;
      held     <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      to_cnt <= (byte_valid || state_nxt == IDLE) ? '0 : to_cnt + 1'b1;
      held   <= held_nxt;
      if (vld_p0 && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Stage p1: command FIFO toward the game logic
  cmd_fifo #(
    .DATA_W (4),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK100MHZ),
    .rst       (CPU_RESET),
    .push      (vld_p0),
    .push_data (key_p0.code),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign cmd_valid = !fifo_empty;
  assign pop       = cmd_valid && cmd_ready;
  assign cmd       = fifo_empty ? CMD_NONE : fifo_head;

endmodule
